instr_mem_loader: RTL
=====================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory address width (256 words).
REQ-002 SHALL have parameter DATA_W, default 16, meaning instruction word width; two bytes per word.
REQ-003 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have: start_load  in  1  request to begin a program load.
REQ-006 SHALL have: load_count  in  ADDR_W+1  number of words to load (1..256), sampled on accepted start_load.
REQ-007 SHALL have: abort  in  1  cancel an in-progress load.
REQ-008 SHALL have: byte_in  in  8  / byte_valid  in  1  / byte_ready  out  1: program byte stream with valid/ready handshake.
REQ-009 SHALL have: pc  in  ADDR_W  CPU fetch address.
REQ-010 SHALL have: mem_addr  out  ADDR_W  / mem_wdata  out  DATA_W  / mem_we  out  1: instruction-memory port.
REQ-011 SHALL have: cpu_stall  out  1  / busy  out  1  / load_done  out  1  / load_err  out  1.

Function
REQ-012 SHALL implement FSM states IDLE, RX_HI, RX_LO, WRITE, CHK (CHK present only per REQ-025).
REQ-013 IDLE: start_load=1 and load_count in 1..256 SHALL latch count, clear address counter to 0, clear load_err, go to RX_HI next cycle.
REQ-014 IDLE: start_load=1 with load_count=0 or >256 SHALL set load_err for one cycle and remain in IDLE.
REQ-015 A byte SHALL transfer only in a cycle with byte_valid=1 and byte_ready=1; byte_ready=1 only in RX_HI, RX_LO, CHK.
REQ-016 RX_HI SHALL capture byte into mem_wdata[15:8], go to RX_LO; RX_LO SHALL capture into mem_wdata[7:0], go to WRITE.
REQ-017 WRITE SHALL assert mem_we for exactly one cycle at current address, then increment address and remaining-word count; next state RX_HI if words remain, else CHK (if enabled) or IDLE.
REQ-018 Address counter SHALL be ADDR_W bits; a 256-word load writes 0..255 with no wrap beyond the last write; word counter SHALL be ADDR_W+1 bits.
REQ-019 mem_addr SHALL equal internal load address when busy=1, else pc (combinational mux).
REQ-020 busy and cpu_stall SHALL be 1 in every state except IDLE.
REQ-021 load_done SHALL pulse one cycle on the cycle the FSM returns to IDLE after a successful load.
REQ-022 start_load while busy SHALL be ignored.
REQ-023 abort=1 in any non-IDLE state SHALL return FSM to IDLE next cycle, deassert mem_we, no load_done, no load_err; abort has priority over a simultaneous byte transfer or write.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, address/word counters 0, mem_wdata 0, mem_we 0, byte_ready 0, busy 0, cpu_stall 0, load_done 0, load_err 0.

Configuration
REQ-025 With macro INSTR_LOADER_CHECKSUM_EN defined: running XOR of all data bytes SHALL be kept; after last WRITE, CHK accepts one byte; match -> load_done pulse; mismatch -> load_err pulse, no load_done; then IDLE.
REQ-026 Without INSTR_LOADER_CHECKSUM_EN: no CHK state, no XOR register; last WRITE goes directly to IDLE with load_done.

Structure
REQ-027 State encoding enum and BYTES_PER_WORD constant SHALL reside in shared package instr_pkg.
REQ-028 Byte-to-word assembly (RX_HI/RX_LO capture) SHALL be sub-module byte_packer; FSM and counters stay in top.

Verification
REQ-029 Reset mid-load (after 3 words of 5) -> all outputs 0, mem_addr follows pc=8'h42.
REQ-030 load_count=2, bytes 12 34 AB CD -> mem_we at addr 0 data 16'h1234, addr 1 data 16'hABCD, then load_done pulse, busy=0.
REQ-031 byte_valid toggled randomly during 4-word load -> same writes as gap-free stream, no byte lost or duplicated.
REQ-032 load_count=256 -> 256 writes addr 0..255, last at 8'hFF, load_done once; load_count=0 -> load_err pulse, busy stays 0.
REQ-033 abort asserted in RX_LO of word 1 -> IDLE next cycle, no mem_we, no load_done; start_load during busy ignored.
REQ-034 With INSTR_LOADER_CHECKSUM_EN, bytes 01 02 + checksum 03 -> load_done; checksum 00 -> load_err, no load_done.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared state encoding and constants for the instruction loader (INSTR_LOADER_CHECKSUM_EN adds CHK)
package instr_pkg;

  localparam int BYTES_PER_WORD = 2;

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RX_HI = 3'd1,
    ST_RX_LO = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHK   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RX_HI = 3'd1,
    ST_RX_LO = 3'd2,
    ST_WRITE = 3'd3
  } state_e;
`endif

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte stream, CPU fetch address and instruction-memory port bundle
interface instr_mem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  // Loader side: consumes the byte stream and the fetch address, drives the memory port
  modport master (
    input  byte_in, byte_valid, pc,
    output byte_ready, mem_addr, mem_wdata, mem_we
  );

  // Environment side: byte source, CPU and instruction memory
  modport slave (
    output byte_in, byte_valid, pc,
    input  byte_ready, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// rtl/instr_mem_loader_byte_packer.sv - assembles high/low program bytes into one instruction word
module byte_packer
  import instr_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cap_hi_i,
  input  logic                             cap_lo_i,
  input  logic [DATA_W/BYTES_PER_WORD-1:0] byte_i,
  output logic [DATA_W-1:0]                word_o
);

  localparam int BYTE_W = DATA_W / BYTES_PER_WORD;

  logic [DATA_W-1:0] word_q, word_d;

  // Steer the accepted byte into the upper or lower half of the word
  always_comb begin
    word_d = word_q;
    if (cap_hi_i) word_d[DATA_W-1 -: BYTE_W] = byte_i;
    if (cap_lo_i) word_d[BYTE_W-1:0]         = byte_i;
  end

  // Word register, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign word_o = word_q;

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loads a byte-streamed program into instruction memory while stalling the CPU (INSTR_LOADER_CHECKSUM_EN adds XOR checksum)
module instr_mem_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_load,
  input  logic [ADDR_W:0]       load_count,
  input  logic                  abort,
  instr_mem_loader_if.master    bus,
  output logic                  cpu_stall,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err
);

  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W:0]   words_inc;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cap_hi, cap_lo;
  logic              ready_c, we_c;
  logic              count_ok;
  logic              start_acc;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  assign count_ok  = (load_count != '0) && (load_count <= MAX_WORDS);
  assign start_acc = (state_q == ST_IDLE) && start_load && count_ok;
  assign words_inc = words_q + 1'b1;

  // Next-state, counter and handshake decode; abort overrides any transfer or write
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    words_d = words_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cap_hi  = 1'b0;
    cap_lo  = 1'b0;
    ready_c = 1'b0;
    we_c    = 1'b0;
    if ((state_q != ST_IDLE) && abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_load) begin
            if (count_ok) begin
              count_d = load_count;
              addr_d  = '0;
              words_d = '0;
              state_d = ST_RX_HI;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_RX_HI: begin
          ready_c = 1'b1;
          if (bus.byte_valid) begin
            cap_hi  = 1'b1;
            state_d = ST_RX_LO;
          end
        end
        ST_RX_LO: begin
          ready_c = 1'b1;
          if (bus.byte_valid) begin
            cap_lo  = 1'b1;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          we_c    = 1'b1;
          words_d = words_inc;
          if (words_inc == count_q) begin
            // Address holds on the last write so a full-depth load never wraps
`ifdef INSTR_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            done_d  = 1'b1;
            state_d = ST_IDLE;
`endif
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_RX_HI;
          end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        ST_CHK: begin
          ready_c = 1'b1;
          if (bus.byte_valid) begin
            if (bus.byte_in == xor_q) done_d = 1'b1;
            else                      err_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, counters and status pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      words_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      words_q <= words_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  // Running XOR of every accepted data byte, restarted with each load
  always_comb begin
    xor_d = xor_q;
    if (start_acc)            xor_d = '0;
    else if (cap_hi | cap_lo) xor_d = xor_q ^ bus.byte_in;
  end

  // Checksum accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xor_q <= '0;
    else        xor_q <= xor_d;
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

  byte_packer #(.DATA_W(DATA_W)) u_byte_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_hi_i (cap_hi),
    .cap_lo_i (cap_lo),
    .byte_i   (bus.byte_in),
    .word_o   (bus.mem_wdata)
  );

  assign busy           = (state_q != ST_IDLE);
  assign cpu_stall      = busy;
  assign load_done      = done_q;
  assign load_err       = err_q;
  assign bus.byte_ready = ready_c;
  assign bus.mem_we     = we_c;
  assign bus.mem_addr   = busy ? addr_q : bus.pc;

endmodule
